// File: rtl/shape_cmd_scheduler_if.sv
// Bus bundle between the requester agents / shape_processor pins and
// shape_cmd_scheduler. "slave" is the scheduler's view and "master" is the
// view of whatever drives the requests, consumes responses and models the SFR.
//
// Handshake semantics, both channels: a transfer happens on a rising clock
// edge where valid and ready are both high. The request side may change or
// drop req_valid freely until it is accepted. rsp_valid, once raised, stays
// high with rsp_id/rsp_status unchanged until the transfer takes place.
interface shape_cmd_scheduler_if #(
  parameter int NUM_REQ = 2
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ-1:0]   req_ready;
  logic [2*NUM_REQ-1:0] req_shape;
  logic [5*NUM_REQ-1:0] req_operation;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [ID_W-1:0]      rsp_id;
  logic [1:0]           rsp_status;
  logic                 sp_write;
  logic [31:0]          sp_write_data;
  logic                 sp_read;
  logic [31:0]          sp_read_data;
  logic                 sp_error;

  modport slave (
    input  req_valid, req_shape, req_operation, rsp_ready, sp_read_data, sp_error,
    output req_ready, rsp_valid, rsp_id, rsp_status, sp_write, sp_write_data, sp_read
  );

  modport master (
    output req_valid, req_shape, req_operation, rsp_ready, sp_read_data, sp_error,
    input  req_ready, rsp_valid, rsp_id, rsp_status, sp_write, sp_write_data, sp_read
  );
endinterface

// File: rtl/shape_cmd_scheduler.sv
// shape_cmd_scheduler: round-robin arbiter in front of the shape_processor
// SFR port. One command in flight: legality check, SFR write, optional
// readback compare, then a held response to the requester.
// Optional feature macro: SHAPE_CMD_SCHEDULER_READBACK_EN (adds READ/WAIT
// and the MISMATCH status; without it sp_read stays 0).
// dbg_state exposes the FSM state for checkers.
module shape_cmd_scheduler #(
  parameter int NUM_REQ      = 2,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  shape_cmd_scheduler_if.slave  bus,
  output logic [2:0]            dbg_state
);
  localparam int ID_W = $clog2(NUM_REQ);

  localparam logic [1:0] ST_OK       = 2'b00;
  localparam logic [1:0] ST_ILLEGAL  = 2'b01;
  localparam logic [1:0] ST_MISMATCH = 2'b10;
  localparam logic [1:0] ST_SP_ERROR = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_WRITE = 3'd2,
`ifdef SHAPE_CMD_SCHEDULER_READBACK_EN
    S_READ  = 3'd3,
    S_WAIT  = 3'd4,
`endif
    S_RESP  = 3'd5
  } state_t;

  state_t          state_q, state_d;
  logic [ID_W-1:0] ptr_q, ptr_d;
  logic [ID_W-1:0] id_q, id_d;
  logic [1:0]      shape_q, shape_d;
  logic [4:0]      op_q, op_d;
  logic            err_q, err_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [1:0]      status_q, status_d;
`ifdef SHAPE_CMD_SCHEDULER_READBACK_EN
  logic [2:0]      cnt_q, cnt_d;
`endif

  logic               found;
  int                 g_idx;
  logic [NUM_REQ-1:0] req_ready_c;
  logic               legal;
  logic               unused_rd;

  // Round-robin search: first valid requester at or above the pointer, with wrap.
  always_comb begin
    int idx;
    found = 1'b0;
    g_idx = 0;
    idx   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr_q) + k) % NUM_REQ;
      if (!found && bus.req_valid[idx]) begin
        found = 1'b1;
        g_idx = idx;
      end
    end
  end

  // Only shapes 01/10 and the five supported operations may reach the SFR.
  always_comb begin
    legal = ((shape_q == 2'b01) || (shape_q == 2'b10)) &&
            ((op_q == 5'd0) || (op_q == 5'd1) || (op_q == 5'd8) ||
             (op_q == 5'd16) || (op_q == 5'd17));
  end

  // Next-state, captured command and strobe decode.
  always_comb begin
    state_d               = state_q;
    ptr_d                 = ptr_q;
    id_d                  = id_q;
    shape_d               = shape_q;
    op_d                  = op_q;
    err_d                 = err_q;
    rsp_valid_d           = rsp_valid_q;
    status_d              = status_q;
`ifdef SHAPE_CMD_SCHEDULER_READBACK_EN
    cnt_d                 = cnt_q;
`endif
    req_ready_c           = '0;
    bus.sp_write          = 1'b0;
    bus.sp_write_data     = '0;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          req_ready_c[g_idx] = 1'b1;
          id_d    = ID_W'(g_idx);
          shape_d = bus.req_shape[2*g_idx +: 2];
          op_d    = bus.req_operation[5*g_idx +: 5];
          ptr_d   = (g_idx == NUM_REQ - 1) ? '0 : ID_W'(g_idx + 1);
          err_d   = 1'b0;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (legal) begin
          state_d = S_WRITE;
        end else begin
          status_d    = ST_ILLEGAL;
          rsp_valid_d = 1'b1;
          state_d     = S_RESP;
        end
      end
      S_WRITE: begin
        bus.sp_write      = 1'b1;
        bus.sp_write_data = {14'b0, shape_q, 11'b0, op_q};
        err_d             = err_q | bus.sp_error;
`ifdef SHAPE_CMD_SCHEDULER_READBACK_EN
        state_d           = S_READ;
`else
        status_d          = (err_q | bus.sp_error) ? ST_SP_ERROR : ST_OK;
        rsp_valid_d       = 1'b1;
        state_d           = S_RESP;
`endif
      end
`ifdef SHAPE_CMD_SCHEDULER_READBACK_EN
      S_READ: begin
        err_d   = err_q | bus.sp_error;
        cnt_d   = 3'd1;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        err_d = err_q | bus.sp_error;
        if (cnt_q == 3'(READ_LATENCY)) begin
          if (err_q | bus.sp_error) begin
            status_d = ST_SP_ERROR;
          end else if ((bus.sp_read_data[17:16] != shape_q) ||
                       (bus.sp_read_data[4:0] != op_q)) begin
            status_d = ST_MISMATCH;
          end else begin
            status_d = ST_OK;
          end
          rsp_valid_d = 1'b1;
          state_d     = S_RESP;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
`endif
      S_RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and captured-command registers; reset aborts any command in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      id_q        <= '0;
      shape_q     <= '0;
      op_q        <= '0;
      err_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      status_q    <= '0;
`ifdef SHAPE_CMD_SCHEDULER_READBACK_EN
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      id_q        <= id_d;
      shape_q     <= shape_d;
      op_q        <= op_d;
      err_q       <= err_d;
      rsp_valid_q <= rsp_valid_d;
      status_q    <= status_d;
`ifdef SHAPE_CMD_SCHEDULER_READBACK_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  // req_ready is combinational from IDLE, so hold it low while reset is asserted.
  assign bus.req_ready  = rst_n ? req_ready_c : '0;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_id     = id_q;
  assign bus.rsp_status = status_q;
`ifdef SHAPE_CMD_SCHEDULER_READBACK_EN
  assign bus.sp_read    = (state_q == S_READ);
`else
  assign bus.sp_read    = 1'b0;
`endif
  assign unused_rd      = ^bus.sp_read_data;
  assign dbg_state      = state_q;
endmodule

// File: tb/tb_shape_cmd_scheduler.sv
// Testbench for shape_cmd_scheduler: directed scenarios plus randomized
// commands checked against a behavioural model of arbitration, legality,
// latency and status priority.
module tb_shape_cmd_scheduler;
  localparam int NUM_REQ = 3;
  localparam int LAT     = 1;
  localparam int ID_W    = $clog2(NUM_REQ);
`ifdef SHAPE_CMD_SCHEDULER_READBACK_EN
  localparam int RB = 1;
`else
  localparam int RB = 0;
`endif
  localparam logic [1:0] ST_OK       = 2'b00;
  localparam logic [1:0] ST_ILLEGAL  = 2'b01;
  localparam logic [1:0] ST_MISMATCH = 2'b10;
  localparam logic [1:0] ST_SP_ERROR = 2'b11;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  shape_cmd_scheduler_if #(.NUM_REQ(NUM_REQ)) bus ();
  logic [2:0] dbg_state;

  shape_cmd_scheduler #(.NUM_REQ(NUM_REQ), .READ_LATENCY(LAT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  int checks   = 0;
  int failures = 0;
  int mptr     = 0;
  logic [1:0] cmd_shape [NUM_REQ];
  logic [4:0] cmd_op    [NUM_REQ];
  int legal_ops [5] = '{0, 1, 8, 16, 17};

  // ---------------- reference model ----------------
  function automatic bit is_legal(input logic [1:0] s, input logic [4:0] o);
    return ((s == 2'b01) || (s == 2'b10)) && (o inside {5'd0, 5'd1, 5'd8, 5'd16, 5'd17});
  endfunction

  function automatic logic [31:0] fmt(input logic [1:0] s, input logic [4:0] o);
    return {14'b0, s, 11'b0, o};
  endfunction

  function automatic int pick(input logic [NUM_REQ-1:0] m, input int p);
    for (int k = 0; k < NUM_REQ; k++) begin
      if (m[(p + k) % NUM_REQ]) return (p + k) % NUM_REQ;
    end
    return -1;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_cmds(input logic [NUM_REQ-1:0] vmask);
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.req_shape[2*i +: 2]     = cmd_shape[i];
      bus.req_operation[5*i +: 5] = cmd_op[i];
    end
    bus.req_valid = vmask;
  endtask

  task automatic check_all_zero(input string tag);
    checks++;
    if (bus.req_ready !== '0 || bus.rsp_valid !== 1'b0 || bus.rsp_id !== '0 ||
        bus.rsp_status !== 2'b00 || bus.sp_write !== 1'b0 ||
        bus.sp_write_data !== 32'h0 || bus.sp_read !== 1'b0) begin
      failures++;
      $display("FAIL %s outputs got rdy=%b rv=%b id=%0d st=%0d wr=%b wd=%h rd=%b exp all zero",
               tag, bus.req_ready, bus.rsp_valid, bus.rsp_id, bus.rsp_status,
               bus.sp_write, bus.sp_write_data, bus.sp_read);
    end
  endtask

  // Issue one arbitration round from vmask (called at posedge+1 while the DUT is idle),
  // follow the command to its response, hold rsp_ready low for 'hold' cycles, then accept.
  task automatic issue(input string tag, input logic [NUM_REQ-1:0] vmask,
                       input logic [31:0] rd, input int err_at, input int hold);
    int g, wr_cyc, wr_n, rd_cyc, rd_n, rsp_cyc, last, exp_rsp, exp_wr, exp_rd, exp_wr_n;
    logic [NUM_REQ-1:0] exp_rdy;
    logic [31:0] wr_data, exp_wd;
    logic [1:0]  got_st, exp_st;
    logic [ID_W-1:0] got_id;
    bit lg, err_hit, mis;
    drive_cmds(vmask);
    bus.sp_read_data = rd;
    g = pick(vmask, mptr);
    exp_rdy = '0;
    exp_rdy[g] = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.req_ready !== exp_rdy) begin
      failures++;
      $display("FAIL %s grant got=%b exp=%b", tag, bus.req_ready, exp_rdy);
    end
    mptr = (g + 1) % NUM_REQ;
    lg = is_legal(cmd_shape[g], cmd_op[g]);
    wr_cyc = -1; wr_n = 0; rd_cyc = -1; rd_n = 0; rsp_cyc = -1;
    wr_data = '0; got_st = '0; got_id = '0;
    @(posedge clk); #1;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      bus.sp_error = (cyc == err_at);
      @(negedge clk);
      if (bus.sp_write === 1'b1) begin wr_n++; wr_cyc = cyc; wr_data = bus.sp_write_data; end
      if (bus.sp_read === 1'b1) begin rd_n++; rd_cyc = cyc; end
      if (bus.rsp_valid === 1'b1) begin
        rsp_cyc = cyc; got_st = bus.rsp_status; got_id = bus.rsp_id;
        break;
      end
      @(posedge clk); #1;
    end
    bus.sp_error = 1'b0;
    last     = 2 + RB * (1 + LAT);
    exp_rsp  = lg ? (3 + RB * (1 + LAT)) : 2;
    exp_wr   = lg ? 2 : -1;
    exp_wr_n = lg ? 1 : 0;
    exp_rd   = (lg && RB == 1) ? 3 : -1;
    exp_wd   = lg ? fmt(cmd_shape[g], cmd_op[g]) : 32'h0;
    err_hit  = lg && (err_at >= 2) && (err_at <= last);
    mis      = (RB == 1) && ((rd[17:16] != cmd_shape[g]) || (rd[4:0] != cmd_op[g]));
    exp_st   = !lg ? ST_ILLEGAL : err_hit ? ST_SP_ERROR : mis ? ST_MISMATCH : ST_OK;
    checks++;
    if (rsp_cyc != exp_rsp) begin
      failures++;
      $display("FAIL %s rsp_cycle got=%0d exp=%0d (state=%0d)", tag, rsp_cyc, exp_rsp, dbg_state);
    end
    checks++;
    if (got_st !== exp_st) begin
      failures++;
      $display("FAIL %s status got=%0d exp=%0d", tag, got_st, exp_st);
    end
    checks++;
    if (got_id !== ID_W'(g)) begin
      failures++;
      $display("FAIL %s rsp_id got=%0d exp=%0d", tag, got_id, g);
    end
    checks++;
    if (wr_n != exp_wr_n || wr_cyc != exp_wr || wr_data !== exp_wd) begin
      failures++;
      $display("FAIL %s sp_write got n=%0d cyc=%0d data=%h exp n=%0d cyc=%0d data=%h",
               tag, wr_n, wr_cyc, wr_data, exp_wr_n, exp_wr, exp_wd);
    end
    checks++;
    if (rd_cyc != exp_rd || rd_n != (exp_rd < 0 ? 0 : 1)) begin
      failures++;
      $display("FAIL %s sp_read got n=%0d cyc=%0d exp cyc=%0d", tag, rd_n, rd_cyc, exp_rd);
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_status !== exp_st ||
          bus.rsp_id !== ID_W'(g) || bus.req_ready !== '0) begin
        failures++;
        $display("FAIL %s hold rv=%b st=%0d id=%0d rdy=%b exp rv=1 st=%0d id=%0d rdy=0",
                 tag, bus.rsp_valid, bus.rsp_status, bus.rsp_id, bus.req_ready, exp_st, g);
      end
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    bus.req_valid = '0;
    checks++;
    if (bus.rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL %s rsp_drop got=%b exp=0", tag, bus.rsp_valid);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    bus.req_valid = '1;
    #12;
    check_all_zero("reset");
    bus.req_valid = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    mptr = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_legal_path();
    cmd_shape[0] = 2'b01; cmd_op[0] = 5'd1;
    issue("legal", 3'b001, 32'h0001_0001, -1, 0);
    cmd_shape[2] = 2'b10; cmd_op[2] = 5'd17;
    issue("legal_hi", 3'b100, fmt(2'b10, 5'd17), -1, 0);
  endtask

  task automatic test_illegal();
    cmd_shape[1] = 2'b11; cmd_op[1] = 5'd0;
    issue("illegal_shape", 3'b010, 32'h0, 2, 0);
    cmd_shape[0] = 2'b10; cmd_op[0] = 5'd2;
    issue("illegal_op", 3'b001, 32'h0, -1, 0);
    cmd_shape[2] = 2'b00; cmd_op[2] = 5'd31;
    issue("illegal_both", 3'b100, 32'h0, -1, 0);
  endtask

  task automatic test_round_robin();
    cmd_shape[0] = 2'b01; cmd_op[0] = 5'd8;
    cmd_shape[1] = 2'b10; cmd_op[1] = 5'd16;
    for (int i = 0; i < 4; i++) issue("rr_pair", 3'b011, fmt(2'b01, 5'd8), -1, 0);
    issue("rr_single", 3'b010, fmt(2'b10, 5'd16), -1, 0);
    issue("rr_single", 3'b010, fmt(2'b10, 5'd16), -1, 0);
    cmd_shape[2] = 2'b01; cmd_op[2] = 5'd0;
    for (int i = 0; i < 4; i++) issue("rr_all", 3'b111, 32'h0, -1, 0);
  endtask

  task automatic test_status_priority();
    int last;
    last = 2 + RB * (1 + LAT);
    cmd_shape[0] = 2'b01; cmd_op[0] = 5'd1;
    issue("mismatch", 3'b001, 32'h0001_0000, -1, 0);
    issue("ignored_bits", 3'b001, 32'h0001_0001 | 32'hFFFC_FFE0, -1, 0);
    issue("err_write", 3'b001, 32'h0001_0001, 2, 0);
    issue("err_last", 3'b001, 32'h0001_0000, last, 0);
    issue("err_check", 3'b001, 32'h0001_0001, 1, 0);
    issue("err_resp", 3'b001, 32'h0001_0001, last + 1, 0);
  endtask

  task automatic test_backpressure();
    cmd_shape[0] = 2'b10; cmd_op[0] = 5'd0;
    cmd_shape[1] = 2'b01; cmd_op[1] = 5'd17;
    issue("backpressure", 3'b011, fmt(2'b10, 5'd0), -1, 10);
    issue("after_release", 3'b011, fmt(2'b01, 5'd17), -1, 0);
  endtask

  task automatic test_reset_mid();
    cmd_shape[0] = 2'b01; cmd_op[0] = 5'd1;
    drive_cmds(3'b001);
    bus.sp_read_data = 32'h0001_0001;
    @(negedge clk);
    @(posedge clk); #1;
    bus.req_valid = '0;
    repeat (1 + 2 * RB) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("reset_mid");
    @(posedge clk); #1;
    rst_n = 1'b1;
    mptr = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if (bus.rsp_valid !== 1'b0 || bus.sp_write !== 1'b0 || bus.sp_read !== 1'b0) begin
        failures++;
        $display("FAIL reset_abort rv=%b wr=%b rd=%b exp all 0", bus.rsp_valid, bus.sp_write, bus.sp_read);
      end
    end
    @(posedge clk); #1;
    cmd_shape[1] = 2'b10; cmd_op[1] = 5'd8;
    issue("post_reset", 3'b011, fmt(2'b01, 5'd1), -1, 0);
  endtask

  task automatic test_random();
    logic [NUM_REQ-1:0] m;
    logic [31:0] rd, fd;
    int g, last, err_at, r;
    last = 2 + RB * (1 + LAT);
    for (int n = 0; n < 60; n++) begin
      m = NUM_REQ'($urandom_range(1, (1 << NUM_REQ) - 1));
      for (int i = 0; i < NUM_REQ; i++) begin
        cmd_shape[i] = 2'($urandom_range(0, 3));
        cmd_op[i] = ($urandom_range(0, 1) == 0) ? 5'(legal_ops[$urandom_range(0, 4)])
                                                : 5'($urandom_range(0, 31));
      end
      g  = pick(m, mptr);
      fd = fmt(cmd_shape[g], cmd_op[g]);
      r  = $urandom_range(0, 3);
      case (r)
        0: rd = fd;
        1: rd = fd ^ (32'h1 << (($urandom_range(0, 1) == 0) ? $urandom_range(16, 17) : $urandom_range(0, 4)));
        2: rd = fd ^ ($urandom() & 32'hFFFC_FFE0);
        default: rd = $urandom();
      endcase
      err_at = ($urandom_range(0, 3) == 0) ? $urandom_range(1, last + 1) : -1;
      issue("random", m, rd, err_at, $urandom_range(0, 3));
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst_n = 1'b0;
    bus.req_valid = '0;
    bus.req_shape = '0;
    bus.req_operation = '0;
    bus.rsp_ready = 1'b0;
    bus.sp_read_data = '0;
    bus.sp_error = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin cmd_shape[i] = '0; cmd_op[i] = '0; end
    test_reset();
    test_legal_path();
    test_illegal();
    test_round_robin();
    test_status_priority();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached (state=%0d)", dbg_state);
    $fatal(1, "watchdog");
  end
endmodule
